// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU opcodes,
// forward-select encoding and a saturating counter helper.
package id_ex_stage_pkg;

   // ALU operation encodings carried from decode into execute
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;

   // Width of the bubble/flush event counter
   localparam int unsigned BCNT_W = 16;

   // Which pipeline stage supplies an EX operand
   typedef enum logic [1:0] {
      FWD_NONE  = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] value);
      logic [BCNT_W-1:0] result;
      if (value == {BCNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(BCNT_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one EX source register. The youngest producer
// (EX/MEM) beats the older one (MEM/WB); register 0 is never forwarded.
import id_ex_stage_pkg::*;

module fwd_unit #(
   parameter int XLEN = 32,
   parameter int RW   = 5
) (
   input  logic [RW-1:0]   ex_rs,
   input  logic [XLEN-1:0] ex_rdata,
   input  logic            exmem_regwrite,
   input  logic [RW-1:0]   exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_regwrite,
   input  logic [RW-1:0]   memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] fwd_data
);

   fwd_sel_e sel_s;
   logic     exmem_hit_s;
   logic     memwb_hit_s;

   // Detect producers that write the register EX is about to read
   always_comb begin
      exmem_hit_s = exmem_regwrite && (exmem_rd != {RW{1'b0}}) && (exmem_rd == ex_rs);
      memwb_hit_s = memwb_regwrite && (memwb_rd != {RW{1'b0}}) && (memwb_rd == ex_rs);
      if (exmem_hit_s) begin
         sel_s = FWD_EXMEM;
      end else if (memwb_hit_s) begin
         sel_s = FWD_MEMWB;
      end else begin
         sel_s = FWD_NONE;
      end
   end

   // Route the selected source onto the operand
   always_comb begin
      case (sel_s)
         FWD_EXMEM: fwd_data = exmem_result;
         FWD_MEMWB: fwd_data = memwb_result;
         FWD_NONE:  fwd_data = ex_rdata;
         default:   fwd_data = ex_rdata;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble
// insertion, flush/stall control and operand forwarding into the ALU.
import id_ex_stage_pkg::*;

module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [RW-1:0]   id_rs1,
   input  logic [RW-1:0]   id_rs2,
   input  logic [RW-1:0]   id_rd,
   input  logic [XLEN-1:0] id_rdata1,
   input  logic [XLEN-1:0] id_rdata2,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alusrc,
   input  logic [3:0]      id_aluop,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic            exmem_regwrite,
   input  logic [RW-1:0]   exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_regwrite,
   input  logic [RW-1:0]   memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] data1,
   output logic [XLEN-1:0] data2,
   output logic [3:0]      aluoperation,
   output logic            ex_valid,
   output logic [RW-1:0]   ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic [XLEN-1:0] ex_store_data,
   output logic            load_use_hazard,
   output logic [15:0]     bubble_count
);

   // EX stage state
   logic              ex_valid_q,    ex_valid_d;
   logic [RW-1:0]     ex_rs1_q,      ex_rs1_d;
   logic [RW-1:0]     ex_rs2_q,      ex_rs2_d;
   logic [RW-1:0]     ex_rd_q,       ex_rd_d;
   logic [XLEN-1:0]   ex_rdata1_q,   ex_rdata1_d;
   logic [XLEN-1:0]   ex_rdata2_q,   ex_rdata2_d;
   logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
   logic              ex_alusrc_q,   ex_alusrc_d;
   logic [3:0]        ex_aluop_q,    ex_aluop_d;
   logic              ex_regwrite_q, ex_regwrite_d;
   logic              ex_memread_q,  ex_memread_d;
   logic              ex_memwrite_q, ex_memwrite_d;
   logic [BCNT_W-1:0] bubble_count_q, bubble_count_d;

   logic              hazard_s;
   logic              kill_s;
   logic [XLEN-1:0]   fwd1_s;
   logic [XLEN-1:0]   fwd2_s;

   // Load-use hazard: the instruction in EX is a load whose destination
   // the instruction in ID reads, so its data is not yet available.
   always_comb begin
      hazard_s = id_valid && ex_valid_q && ex_memread_q &&
                 (ex_rd_q != {RW{1'b0}}) &&
                 ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
      // A flush always empties EX; a hazard does so only when not stalled
      kill_s = flush || (!stall && hazard_s);
   end

   // Next EX contents: empty slot on flush/bubble, hold on stall, else load ID
   always_comb begin
      ex_valid_d     = ex_valid_q;
      ex_rs1_d       = ex_rs1_q;
      ex_rs2_d       = ex_rs2_q;
      ex_rd_d        = ex_rd_q;
      ex_rdata1_d    = ex_rdata1_q;
      ex_rdata2_d    = ex_rdata2_q;
      ex_imm_d       = ex_imm_q;
      ex_alusrc_d    = ex_alusrc_q;
      ex_aluop_d     = ex_aluop_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_memread_d   = ex_memread_q;
      ex_memwrite_d  = ex_memwrite_q;
      bubble_count_d = bubble_count_q;
      if (kill_s) begin
         ex_valid_d     = 1'b0;
         ex_rs1_d       = {RW{1'b0}};
         ex_rs2_d       = {RW{1'b0}};
         ex_rd_d        = {RW{1'b0}};
         ex_rdata1_d    = {XLEN{1'b0}};
         ex_rdata2_d    = {XLEN{1'b0}};
         ex_imm_d       = {XLEN{1'b0}};
         ex_alusrc_d    = 1'b0;
         ex_aluop_d     = ALU_ADD;
         ex_regwrite_d  = 1'b0;
         ex_memread_d   = 1'b0;
         ex_memwrite_d  = 1'b0;
         bubble_count_d = sat_inc(bubble_count_q);
      end else if (stall) begin
         // every EX register keeps its value (defaults above)
         ex_valid_d = ex_valid_q;
      end else begin
         ex_valid_d  = id_valid;
         ex_rs1_d    = id_rs1;
         ex_rs2_d    = id_rs2;
         ex_rd_d     = id_rd;
         ex_rdata1_d = id_rdata1;
         ex_rdata2_d = id_rdata2;
         ex_imm_d    = id_imm;
         if (id_valid) begin
            ex_alusrc_d   = id_alusrc;
            ex_aluop_d    = id_aluop;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
            ex_memwrite_d = id_memwrite;
         end else begin
            ex_alusrc_d   = 1'b0;
            ex_aluop_d    = ALU_ADD;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memwrite_d = 1'b0;
         end
      end
   end

   // EX pipeline registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_rs1_q       <= {RW{1'b0}};
         ex_rs2_q       <= {RW{1'b0}};
         ex_rd_q        <= {RW{1'b0}};
         ex_rdata1_q    <= {XLEN{1'b0}};
         ex_rdata2_q    <= {XLEN{1'b0}};
         ex_imm_q       <= {XLEN{1'b0}};
         ex_alusrc_q    <= 1'b0;
         ex_aluop_q     <= ALU_ADD;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         ex_memwrite_q  <= 1'b0;
         bubble_count_q <= {BCNT_W{1'b0}};
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_rs1_q       <= ex_rs1_d;
         ex_rs2_q       <= ex_rs2_d;
         ex_rd_q        <= ex_rd_d;
         ex_rdata1_q    <= ex_rdata1_d;
         ex_rdata2_q    <= ex_rdata2_d;
         ex_imm_q       <= ex_imm_d;
         ex_alusrc_q    <= ex_alusrc_d;
         ex_aluop_q     <= ex_aluop_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         ex_memwrite_q  <= ex_memwrite_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   fwd_unit #(.XLEN(XLEN), .RW(RW)) u_fwd_rs1 (
      .ex_rs          (ex_rs1_q),
      .ex_rdata       (ex_rdata1_q),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .fwd_data       (fwd1_s)
   );

   fwd_unit #(.XLEN(XLEN), .RW(RW)) u_fwd_rs2 (
      .ex_rs          (ex_rs2_q),
      .ex_rdata       (ex_rdata2_q),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .fwd_data       (fwd2_s)
   );

   // ALU operands: forwarding is combinational so it adds no latency
   always_comb begin
      data1 = fwd1_s;
      if (ex_alusrc_q) begin
         data2 = ex_imm_q;
      end else begin
         data2 = fwd2_s;
      end
      ex_store_data = fwd2_s;
   end

   // Control outputs are gated by valid so an empty slot never has side effects
   always_comb begin
      aluoperation    = ex_aluop_q;
      ex_valid        = ex_valid_q;
      ex_rd           = ex_rd_q;
      ex_regwrite     = ex_regwrite_q && ex_valid_q;
      ex_memread      = ex_memread_q  && ex_valid_q;
      ex_memwrite     = ex_memwrite_q && ex_valid_q;
      load_use_hazard = hazard_s;
      bubble_count    = bubble_count_q;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// all checked against a pipeline-slot reference model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        id_valid, id_alusrc, id_regwrite, id_memread, id_memwrite;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rdata1, id_rdata2, id_imm;
   logic [3:0]  id_aluop;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] data1, data2, ex_store_data;
   logic [3:0]  aluoperation;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard;
   logic [4:0]  ex_rd;
   logic [15:0] bubble_count;

   int checks = 0;
   int errors = 0;

   // Reference model of the instruction sitting in EX
   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] r1, r2, imm;
      logic        alusrc;
      logic [3:0]  aluop;
      logic        rw, mr, mw;
      int          bc;
   } slot_t;
   slot_t m;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .data1(data1), .data2(data2), .aluoperation(aluoperation),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data),
      .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic slot_t empty_slot(input int bc);
      slot_t s;
      s.valid = 1'b0; s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd0;
      s.r1 = 32'd0; s.r2 = 32'd0; s.imm = 32'd0; s.alusrc = 1'b0;
      s.aluop = 4'b0000; s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.bc = bc;
      return s;
   endfunction

   // Value an EX operand should see given the producers further down the pipe
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] own);
      if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs) return exmem_result;
      if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_result;
      return own;
   endfunction

   function automatic logic model_hazard();
      return id_valid && m.valid && m.mr && m.rd != 5'd0 && (m.rd == id_rs1 || m.rd == id_rs2);
   endfunction

   task automatic check_model();
      chk("ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("ex_regwrite", 32'(ex_regwrite), 32'(m.valid & m.rw));
      chk("ex_memread", 32'(ex_memread), 32'(m.valid & m.mr));
      chk("ex_memwrite", 32'(ex_memwrite), 32'(m.valid & m.mw));
      chk("hazard", 32'(load_use_hazard), 32'(model_hazard()));
      chk("bubble_count", 32'(bubble_count), 32'(m.bc));
      chk("aluoperation", 32'(aluoperation), 32'(m.aluop));
      if (m.valid) begin
         chk("data1", data1, operand(m.rs1, m.r1));
         chk("data2", data2, m.alusrc ? m.imm : operand(m.rs2, m.r2));
         chk("store_data", ex_store_data, operand(m.rs2, m.r2));
         chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      end
   endtask

   // One cycle: check outputs, predict the slot after the edge, move on
   task automatic step();
      slot_t n;
      #1;
      check_model();
      if (flush || (!stall && model_hazard())) begin
         n = empty_slot(m.bc >= 65535 ? 65535 : m.bc + 1);
      end else if (stall) begin
         n = m;
      end else begin
         n = empty_slot(m.bc);
         n.valid = id_valid; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
         n.r1 = id_rdata1; n.r2 = id_rdata2; n.imm = id_imm;
         if (id_valid) begin
            n.alusrc = id_alusrc; n.aluop = id_aluop;
            n.rw = id_regwrite; n.mr = id_memread; n.mw = id_memwrite;
         end
      end
      @(posedge clk);
      m = n;
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic src, input logic [3:0] op,
                         input logic rw, input logic mr, input logic mw);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_alusrc = src;
      id_aluop = op; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
   endtask

   task automatic rand_id();
      set_id(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, 1'($urandom), 4'($urandom_range(0, 4)), 1'($urandom),
             ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, 1'($urandom));
   endtask

   task automatic rand_fwd();
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
      memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
      m = empty_slot(0);

      // Reset state
      @(negedge clk);
      #1;
      check_model();
      chk("rst_data1", data1, 32'd0);
      chk("rst_ex_rd", 32'(ex_rd), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Plain SUB, no forwarding
      set_id(1'b1, 5'd3, 5'd4, 5'd8, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
      step();
      #1;
      chk("sub_data1", data1, 32'd5);
      chk("sub_data2", data2, 32'd7);
      chk("sub_aluop", 32'(aluoperation), 32'h1);

      // EX/MEM wins over MEM/WB, MEM/WB used when EX/MEM drops out
      stall = 1'b1;
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
      memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h20;
      #1 chk("fwd_exmem", data1, 32'h10);
      exmem_regwrite = 1'b0;
      #1 chk("fwd_memwb", data1, 32'h20);
      step();
      stall = 1'b0;

      // Register 0 is never forwarded
      set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
      exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD_BEEF;
      memwb_regwrite = 1'b0;
      step();
      #1 chk("x0_data1", data1, 32'd0);
      exmem_regwrite = 1'b0;

      // Load followed by a dependent instruction inserts one bubble
      set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'd0, 32'd0, 32'd4, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
      #1 chk("lu_hazard", 32'(load_use_hazard), 32'd1);
      step();
      #1;
      chk("lu_ex_valid", 32'(ex_valid), 32'd0);
      chk("lu_regwrite", 32'(ex_regwrite), 32'd0);
      chk("lu_bubbles", 32'(bubble_count), 32'd1);
      step();

      // Flush beats stall, then stall holds for three cycles
      stall = 1'b1; flush = 1'b1;
      step();
      #1 chk("flush_over_stall", 32'(ex_valid), 32'd0);
      stall = 1'b0; flush = 1'b0;
      set_id(1'b1, 5'd2, 5'd3, 5'd10, 32'd11, 32'd12, 32'h55, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1);
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         step();
      end
      #1;
      chk("hold_aluop", 32'(aluoperation), 32'h4);
      chk("hold_data2", data2, 32'h55);
      chk("hold_rd", 32'(ex_rd), 32'd10);
      chk("hold_memwrite", 32'(ex_memwrite), 32'd1);

      // Reset in the middle of a stall clears immediately
      #1 reset = 1'b1;
      #1;
      chk("async_ex_valid", 32'(ex_valid), 32'd0);
      chk("async_bubbles", 32'(bubble_count), 32'd0);
      m = empty_slot(0);
      @(negedge clk);
      reset = 1'b0; stall = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'd8, 32'd0, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
      step();
      #1 chk("post_rst_load", 32'(ex_valid), 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_id();
         rand_fwd();
         stall = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
         flush = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
         step();
      end
      #1 check_model();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
